gesture_key_strobe: RTL and testbench



---
 rtl/gesture_key_strobe_pkg.sv | 28 ++
 rtl/gesture_key_strobe_if.sv | 24 ++
 rtl/gesture_key_strobe_flag_sync.sv | 24 ++
 rtl/gesture_key_strobe.sv | 143 ++++++++++++++
 tb/tb_gesture_key_strobe.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/gesture_key_strobe_pkg.sv
// Shared types, key codes and helpers for the gesture key strobe block.
package gesture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUALIFY,
    ST_LOCKOUT,
    ST_HOLD,
    ST_WAIT_RELEASE
  } gks_state_t;

  localparam logic [3:0] GK_NONE  = 4'b0000;
  localparam logic [3:0] GK_UP    = 4'b0001;
  localparam logic [3:0] GK_DOWN  = 4'b0010;
  localparam logic [3:0] GK_LEFT  = 4'b0100;
  localparam logic [3:0] GK_RIGHT = 4'b1000;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != GK_NONE) && ((v & (v - 4'd1)) == GK_NONE);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gesture_key_strobe_if.sv
// Gesture flag in / key strobe and status out bundle between decoder side and controller side.
interface gesture_key_strobe_if;
  logic [3:0] flag_in;
  logic [3:0] key_out;
  logic [3:0] last_key;
  logic       busy;
  logic [7:0] key_cnt;

  modport master (
    output flag_in,
    input  key_out,
    input  last_key,
    input  busy,
    input  key_cnt
  );

  modport slave (
    input  flag_in,
    output key_out,
    output last_key,
    output busy,
    output key_cnt
  );
endinterface

// File: rtl/gesture_key_strobe_flag_sync.sv
// Parameter-width two-flop synchroniser with synchronous active-high clear.
module flag_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sync_p0;
  logic [W-1:0] sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;
endmodule

// File: rtl/gesture_key_strobe.sv
// Qualifies the synchronised gesture flag into single-cycle one-hot key strobes with lockout.
// Optional auto-repeat while a gesture is held is compiled in with GESTURE_REPEAT_EN.
module gesture_key_strobe
  import gesture_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int STABLE_MS  = 20,
  parameter int LOCKOUT_MS = 300,
  parameter int REPEAT_MS  = 500
) (
  input logic                 clk,
  input logic                 rst,
  gesture_key_strobe_if.slave bus
);
  localparam int STABLE_CYC  = CLK_HZ / 1000 * STABLE_MS;
  localparam int LOCKOUT_CYC = CLK_HZ / 1000 * LOCKOUT_MS;
  localparam int REPEAT_CYC  = CLK_HZ / 1000 * REPEAT_MS;
  localparam int CNT_W       = $clog2(max3(STABLE_CYC, LOCKOUT_CYC, REPEAT_CYC)) + 1;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_C  = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] LOCKOUT_C = CNT_W'(LOCKOUT_CYC);
`ifdef GESTURE_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_C  = CNT_W'(REPEAT_CYC);
`endif

  logic [3:0]       s2;
  logic             s2_valid;
  gks_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       cand, cand_nx;
  logic             fire;
  logic [3:0]       key_q;
  logic [3:0]       last_q;
  logic [7:0]       key_cnt_q;

  flag_sync #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.flag_in),
    .q   (s2)
  );

  assign s2_valid = is_onehot4(s2);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // cnt is reloaded on every state change so each state counts from a known origin
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    fire     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (s2_valid) begin
          cand_nx  = s2;
          cnt_nx   = ONE;
          state_nx = ST_QUALIFY;
        end
      end
      ST_QUALIFY: begin
        if (s2 == cand) begin
          if (cnt == STABLE_C) begin
            fire     = 1'b1;
            cnt_nx   = ONE;
            state_nx = ST_LOCKOUT;
          end else begin
            cnt_nx = cnt + ONE;
          end
        end else if (s2_valid) begin
          cand_nx = s2;
          cnt_nx  = ONE;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (cnt == LOCKOUT_C) begin
          if (s2 == GK_NONE) begin
            state_nx = ST_IDLE;
`ifdef GESTURE_REPEAT_EN
          end else if (s2 == last_q) begin
            cnt_nx   = '0;
            state_nx = ST_HOLD;
`endif
          end else begin
            state_nx = ST_WAIT_RELEASE;
          end
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
`ifdef GESTURE_REPEAT_EN
      ST_HOLD: begin
        if (s2 != last_q) begin
          state_nx = ST_WAIT_RELEASE;
        end else if (cnt == REPEAT_C) begin
          fire     = 1'b1;
          cnt_nx   = ONE;
          state_nx = ST_LOCKOUT;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
`endif
      ST_WAIT_RELEASE: begin
        if (s2 == GK_NONE) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == ST_LOCKOUT) || (state == ST_HOLD) || (state == ST_WAIT_RELEASE);
  end

  // In HOLD cand still equals last_q, so a repeat strobe re-emits the same code
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      cand      <= GK_NONE;
      key_q     <= GK_NONE;
      last_q    <= GK_NONE;
      key_cnt_q <= 8'd0;
    end else begin
      cnt   <= cnt_nx;
      cand  <= cand_nx;
      key_q <= fire ? cand : GK_NONE;
      if (fire) begin
        last_q    <= cand;
        key_cnt_q <= key_cnt_q + 8'd1;
      end
    end
  end

  assign bus.key_out  = key_q;
  assign bus.last_key = last_q;
  assign bus.key_cnt  = key_cnt_q;
endmodule

// File: tb/tb_gesture_key_strobe.sv
// Self-checking bench for gesture_key_strobe: vector table, corner sequences, random run vs reference model.
module tb_gesture_key_strobe;
  import gesture_pkg::*;

  localparam int CLK_HZ      = 1000;
  localparam int STABLE_MS   = 4;
  localparam int LOCKOUT_MS  = 10;
  localparam int REPEAT_MS   = 8;
  localparam int STABLE_CYC  = CLK_HZ / 1000 * STABLE_MS;
  localparam int LOCKOUT_CYC = CLK_HZ / 1000 * LOCKOUT_MS;
  localparam int REPEAT_CYC  = CLK_HZ / 1000 * REPEAT_MS;
`ifdef GESTURE_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  gesture_key_strobe_if bus();

  gesture_key_strobe #(
    .CLK_HZ     (CLK_HZ),
    .STABLE_MS  (STABLE_MS),
    .LOCKOUT_MS (LOCKOUT_MS),
    .REPEAT_MS  (REPEAT_MS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: time-based view of the rules, driven by the flag seen two edges late.
  logic [3:0] m_s1 = '0, m_s2 = '0, m_last = '0, m_key = '0, run_code = '0;
  logic [7:0] m_cnt = '0;
  int  now = 0, last_fire = 0, hold_since = 0, run_len = 0;
  bit  lock_active = 0, need_release = 0, holding = 0;

  task automatic model_step(input logic [3:0] f, input logic r);
    logic [3:0] s, fk;
    bit fire;
    s = m_s2; fire = 0; fk = '0;
    if (r) begin
      lock_active = 0; need_release = 0; holding = 0; run_len = 0;
      m_last = '0; m_cnt = '0; m_key = '0; m_s1 = '0; m_s2 = '0;
    end else begin
      if (lock_active) begin
        if (now - last_fire == LOCKOUT_CYC) begin
          lock_active = 0;
          if (s == 4'd0) run_len = 0;
          else if (REPEAT_ON && s == m_last) begin holding = 1; hold_since = now; end
          else need_release = 1;
        end
      end else if (holding) begin
        if (s != m_last) begin holding = 0; need_release = 1; end
        else if (now - hold_since == REPEAT_CYC + 1) begin fire = 1; fk = m_last; end
      end else if (need_release) begin
        if (s == 4'd0) begin need_release = 0; run_len = 0; end
      end else if ($countones(s) == 1) begin
        if (run_len > 0 && s == run_code) run_len++;
        else begin run_code = s; run_len = 1; end
        if (run_len == STABLE_CYC + 1) begin fire = 1; fk = run_code; end
      end else begin
        run_len = 0;
      end
      if (fire) begin
        last_fire = now; lock_active = 1; holding = 0; run_len = 0;
        m_last = fk; m_cnt = m_cnt + 8'd1;
      end
      m_key = fire ? fk : 4'd0;
      m_s2 = m_s1; m_s1 = f;
    end
    now++;
  endtask

  task automatic tick(input logic [3:0] f, input logic r);
    @(negedge clk);
    bus.flag_in = f;
    rst = r;
    @(posedge clk);
    model_step(f, r);
    #1;
    cyc++;
    check("key_out",  {28'd0, bus.key_out},  {28'd0, m_key});
    check("last_key", {28'd0, bus.last_key}, {28'd0, m_last});
    check("busy",     {31'd0, bus.busy},     {31'd0, lock_active || holding || need_release});
    check("key_cnt",  {24'd0, bus.key_cnt},  {24'd0, m_cnt});
  endtask

  typedef struct {
    logic [3:0] code;
    int         hold;
    int         exp_at;
    logic [3:0] exp_key;
  } vec_t;

  vec_t vecs[7];
  int   strobe_at[$];
  logic [3:0] first_key;
  int   n_str;

  initial begin
    bus.flag_in = '0;
    vecs[0] = '{GK_DOWN,  20,  6, GK_DOWN};
    vecs[1] = '{GK_LEFT,   3, -1, GK_NONE};
    vecs[2] = '{4'b0011,  20, -1, GK_NONE};
    vecs[3] = '{GK_RIGHT,  7,  6, GK_RIGHT};
    vecs[4] = '{GK_UP,     5,  6, GK_UP};
    vecs[5] = '{GK_UP,     4, -1, GK_NONE};
    vecs[6] = '{4'b1111,  12, -1, GK_NONE};

    tick(4'd0, 1'b1);
    tick(4'd0, 1'b1);
    check("reset key_out",  {28'd0, bus.key_out},  32'd0);
    check("reset last_key", {28'd0, bus.last_key}, 32'd0);
    check("reset busy",     {31'd0, bus.busy},     32'd0);
    check("reset key_cnt",  {24'd0, bus.key_cnt},  32'd0);
    for (int i = 0; i < 4; i++) tick(4'd0, 1'b0);

    for (int v = 0; v < 7; v++) begin
      strobe_at.delete(); first_key = '0;
      for (int i = 0; i < vecs[v].hold + 30; i++) begin
        tick(i < vecs[v].hold ? vecs[v].code : 4'd0, 1'b0);
        if (bus.key_out != 4'd0) begin
          if (strobe_at.size() == 0) first_key = bus.key_out;
          strobe_at.push_back(i);
        end
      end
      check($sformatf("vec%0d strobes", v), strobe_at.size(), (vecs[v].exp_at >= 0) ? 1 : 0);
      check($sformatf("vec%0d strobe_at", v),
            (strobe_at.size() > 0) ? strobe_at[0] : -1, vecs[v].exp_at);
      check($sformatf("vec%0d key", v), {28'd0, first_key}, {28'd0, vecs[v].exp_key});
    end
    check("vec last_key", {28'd0, bus.last_key}, {28'd0, GK_UP});
    check("vec key_cnt",  {24'd0, bus.key_cnt},  32'd3);

    // Code switch before qualification completes
    strobe_at.delete(); first_key = '0;
    tick(GK_UP, 1'b0); tick(GK_UP, 1'b0);
    for (int i = 0; i < 50; i++) begin
      tick(i < 20 ? GK_RIGHT : 4'd0, 1'b0);
      if (bus.key_out != 4'd0) begin first_key = bus.key_out; strobe_at.push_back(i); end
    end
    check("switch strobes", strobe_at.size(), 1);
    check("switch strobe_at", (strobe_at.size() > 0) ? strobe_at[0] : -1, 6);
    check("switch key", {28'd0, first_key}, {28'd0, GK_RIGHT});

    // Long hold
    strobe_at.delete();
    for (int i = 0; i < 60; i++) begin
      tick(GK_UP, 1'b0);
      if (bus.key_out != 4'd0) strobe_at.push_back(i);
    end
    if (REPEAT_ON) begin
      check("hold strobes", strobe_at.size(), 3);
      check("hold strobe0", (strobe_at.size() > 0) ? strobe_at[0] : -1, 6);
      check("hold strobe1", (strobe_at.size() > 1) ? strobe_at[1] : -1, 25);
      check("hold strobe2", (strobe_at.size() > 2) ? strobe_at[2] : -1, 44);
    end else begin
      check("hold strobes", strobe_at.size(), 1);
      check("hold strobe0", (strobe_at.size() > 0) ? strobe_at[0] : -1, 6);
      check("hold busy", {31'd0, bus.busy}, 32'd1);
    end
    for (int i = 0; i < 30; i++) tick(4'd0, 1'b0);
    check("release busy", {31'd0, bus.busy}, 32'd0);

    // Reset on the edge a strobe would register
    for (int i = 0; i < 6; i++) tick(GK_DOWN, 1'b0);
    tick(GK_DOWN, 1'b1);
    check("rst key_out",  {28'd0, bus.key_out},  32'd0);
    check("rst last_key", {28'd0, bus.last_key}, 32'd0);
    check("rst busy",     {31'd0, bus.busy},     32'd0);
    check("rst key_cnt",  {24'd0, bus.key_cnt},  32'd0);
    for (int i = 0; i < 30; i++) tick(4'd0, 1'b0);

    // 256 strobes wrap the counter
    tick(4'd0, 1'b1);
    n_str = 0;
    for (int k = 0; k < 256; k++) begin
      logic [3:0] c;
      c = 4'b0001 << $urandom_range(0, 3);
      for (int i = 0; i < 17; i++) begin
        tick(i < 5 ? c : 4'd0, 1'b0);
        if (bus.key_out != 4'd0) n_str++;
      end
      if (k == 254) check("cnt at 255", {24'd0, bus.key_cnt}, 32'd255);
    end
    check("wrap strobes", n_str, 256);
    check("wrap key_cnt", {24'd0, bus.key_cnt}, 32'd0);

    // Random runs checked cycle by cycle against the model
    for (int run = 0; run < 250; run++) begin
      logic [3:0] c;
      int sel, len;
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 24);
      if (sel < 3)      c = 4'd0;
      else if (sel < 9) c = 4'b0001 << $urandom_range(0, 3);
      else              c = 4'($urandom_range(0, 15));
      for (int i = 0; i < len; i++) tick(c, ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
